// File: rtl/red_pitaya_asg_bank_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// asg_dbuf_pkg
// Shared definitions for the double-buffered ASG bank-swap controller:
//   - bank_state_t : swap FSM states
//   - CSR bit positions for control writes and status reads
//   - default bank bases and CSR address, also used by the generator and bench
//   - in_window()  : half-open byte-window address match helper
// -----------------------------------------------------------------------------
package asg_dbuf_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        SWAP    = 2'd2
    } bank_state_t;

    // CSR write bits
    localparam int CSR_ARM_BIT    = 0;
    localparam int CSR_CANCEL_BIT = 1;
    localparam int CSR_FORCE_BIT  = 2;

    // CSR status fields
    localparam int CSR_ST_IDLE_BIT = 0;
    localparam int CSR_ST_BANK_BIT = 1;
    localparam int CSR_ST_PEND_BIT = 2;
    localparam int CSR_ST_CNT_LSB  = 16;

    localparam logic [31:0] DEF_B0_BASE  = 32'h0002_0000;
    localparam logic [31:0] DEF_B1_BASE  = 32'h0004_0000;
    localparam logic [31:0] DEF_CSR_ADDR = 32'h0000_0080;

    // True when addr lies in [base, base + win).
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] win);
        return (addr >= base) && (addr < (base + win));
    endfunction

endpackage

// File: rtl/red_pitaya_asg_bank_ctrl_if.sv
// -----------------------------------------------------------------------------
// red_pitaya_asg_bank_ctrl_if
// System-bus slice seen by the bank-swap controller.
//   master : drives sys_addr/sys_wdata/sys_wen/sys_ren, receives rdata/ack/err
//   slave  : the controller side
// -----------------------------------------------------------------------------
interface red_pitaya_asg_bank_ctrl_if;

    logic [31:0] sys_addr;
    logic [31:0] sys_wdata;
    logic        sys_wen;
    logic        sys_ren;
    logic [31:0] sys_rdata;
    logic        sys_ack;
    logic        sys_err;

    modport master (
        output sys_addr, sys_wdata, sys_wen, sys_ren,
        input  sys_rdata, sys_ack, sys_err
    );

    modport slave (
        input  sys_addr, sys_wdata, sys_wen, sys_ren,
        output sys_rdata, sys_ack, sys_err
    );

endinterface

// File: rtl/red_pitaya_asg_bank_ctrl.sv
// -----------------------------------------------------------------------------
// red_pitaya_asg_bank_ctrl
// Bank-swap controller for one ASG channel. Routes bus writes to the two
// waveform RAM banks and flips the played bank only at a table wrap or while
// the generator is idle.
// Ports:
//   dac_clk_i, dac_rst_i : clock, synchronous active-high reset
//   sys                  : bus slave (addr/wdata/wen/ren -> rdata/ack/err)
//   gen_wrap_i           : pulse, generator read pointer wrapped
//   gen_idle_i           : level, generator not playing
//   bank_sel_o           : bank currently played
//   ram_we_o             : one-hot bank write enable
//   ram_waddr_o/wdata_o  : RAM word address / data of the accepted write
//   swap_done_o          : one-cycle pulse when bank_sel_o flips
// -----------------------------------------------------------------------------
module red_pitaya_asg_bank_ctrl
    import asg_dbuf_pkg::*;
#(
    parameter int          RSZ      = 15,
    parameter int          DW       = 14,
    parameter logic [31:0] B0_BASE  = DEF_B0_BASE,
    parameter logic [31:0] B1_BASE  = DEF_B1_BASE,
    parameter logic [31:0] CSR_ADDR = DEF_CSR_ADDR
) (
    input  logic                         dac_clk_i,
    input  logic                         dac_rst_i,
    red_pitaya_asg_bank_ctrl_if.slave    sys,
    input  logic                         gen_wrap_i,
    input  logic                         gen_idle_i,
    output logic                         bank_sel_o,
    output logic [1:0]                   ram_we_o,
    output logic [RSZ-1:0]               ram_waddr_o,
    output logic [DW-1:0]                ram_wdata_o,
    output logic                         swap_done_o
);

    localparam logic [31:0] BANK_WIN = 32'd4 << RSZ;

    bank_state_t    state_q, state_d;
    logic           bank_sel_q, bank_sel_d;
    logic [15:0]    swap_cnt_q, swap_cnt_d;
    logic           arm_req_q, arm_req_d;
    logic           cancel_req_q, cancel_req_d;
    logic           force_req_q, force_req_d;
    logic           ack_q, ack_d;
    logic           err_q, err_d;
    logic [31:0]    rdata_q, rdata_d;
    logic [1:0]     we_q, we_d;
    logic [RSZ-1:0] waddr_q, waddr_d;
    logic [DW-1:0]  wdata_q, wdata_d;
    logic           swap_done_q, swap_done_d;

    logic hit_b0_s, hit_b1_s, hit_csr_s;
    logic judge_sel_s, bank_wr_ok_s, force_ok_s, cancel_wr_s;
    logic w_arm_s, w_cancel_s, w_force_s;
    logic unused_wdata_s;

    assign unused_wdata_s = ^sys.sys_wdata[31:DW];

    // Address decode and write-acceptance terms.
    always_comb begin
        hit_b0_s    = in_window(sys.sys_addr, B0_BASE, BANK_WIN);
        hit_b1_s    = in_window(sys.sys_addr, B1_BASE, BANK_WIN);
        hit_csr_s   = (sys.sys_addr == CSR_ADDR);
        w_arm_s     = sys.sys_wdata[CSR_ARM_BIT];
        w_cancel_s  = sys.sys_wdata[CSR_CANCEL_BIT];
        w_force_s   = sys.sys_wdata[CSR_FORCE_BIT];
        force_ok_s  = w_force_s & gen_idle_i;
        cancel_wr_s = sys.sys_wen & hit_csr_s & w_cancel_s;
        // bank_sel_q has already flipped during SWAP; judge against the old bank.
        judge_sel_s = (state_q == SWAP) ? ~bank_sel_q : bank_sel_q;
        if (hit_b1_s == judge_sel_s) begin
            bank_wr_ok_s = gen_idle_i;
        end else begin
            bank_wr_ok_s = (state_q != PENDING);
        end
    end

    // Bus response, RAM write port and swap FSM next-state logic.
    always_comb begin
        state_d      = state_q;
        bank_sel_d   = bank_sel_q;
        swap_cnt_d   = swap_cnt_q;
        arm_req_d    = 1'b0;
        cancel_req_d = 1'b0;
        force_req_d  = 1'b0;
        ack_d        = 1'b0;
        err_d        = 1'b0;
        rdata_d      = 32'd0;
        we_d         = 2'b00;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        swap_done_d  = 1'b0;

        if (sys.sys_wen) begin
            if (hit_csr_s) begin
                ack_d        = 1'b1;
                // An illegal FORCE is only an error when ARM is not also set.
                err_d        = w_force_s & ~gen_idle_i & ~w_arm_s;
                force_req_d  = force_ok_s;
                arm_req_d    = w_arm_s & ~force_ok_s;
                cancel_req_d = w_cancel_s;
            end else if (hit_b0_s || hit_b1_s) begin
                ack_d = 1'b1;
                if (bank_wr_ok_s) begin
                    we_d    = hit_b1_s ? 2'b10 : 2'b01;
                    waddr_d = sys.sys_addr[RSZ+1:2];
                    wdata_d = sys.sys_wdata[DW-1:0];
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                ack_d = 1'b0;
            end
        end else if (sys.sys_ren) begin
            if (hit_csr_s) begin
                ack_d   = 1'b1;
                rdata_d = {swap_cnt_q, 13'd0, (state_q == PENDING), bank_sel_q, gen_idle_i};
            end else if (hit_b0_s || hit_b1_s) begin
                ack_d = 1'b1;
                err_d = 1'b1;
            end else begin
                ack_d = 1'b0;
            end
        end else begin
            ack_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (force_req_q) begin
                    state_d = SWAP;
                end else if (arm_req_q) begin
                    state_d = PENDING;
                end else begin
                    state_d = IDLE;
                end
            end
            PENDING: begin
                // A CANCEL being written or just registered beats a wrap/idle.
                if (cancel_req_q) begin
                    state_d = IDLE;
                end else if (cancel_wr_s) begin
                    state_d = PENDING;
                end else if (gen_wrap_i || gen_idle_i) begin
                    state_d = SWAP;
                end else begin
                    state_d = PENDING;
                end
            end
            SWAP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_d == SWAP) begin
            bank_sel_d  = ~bank_sel_q;
            swap_cnt_d  = swap_cnt_q + 16'd1;
            swap_done_d = 1'b1;
        end else begin
            swap_done_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge dac_clk_i) begin
        if (dac_rst_i) begin
            state_q      <= IDLE;
            bank_sel_q   <= 1'b0;
            swap_cnt_q   <= 16'd0;
            arm_req_q    <= 1'b0;
            cancel_req_q <= 1'b0;
            force_req_q  <= 1'b0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= 32'd0;
            we_q         <= 2'b00;
            waddr_q      <= '0;
            wdata_q      <= '0;
            swap_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bank_sel_q   <= bank_sel_d;
            swap_cnt_q   <= swap_cnt_d;
            arm_req_q    <= arm_req_d;
            cancel_req_q <= cancel_req_d;
            force_req_q  <= force_req_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            swap_done_q  <= swap_done_d;
        end
    end

    assign sys.sys_ack   = ack_q;
    assign sys.sys_err   = err_q;
    assign sys.sys_rdata = rdata_q;
    assign bank_sel_o    = bank_sel_q;
    assign ram_we_o      = we_q;
    assign ram_waddr_o   = waddr_q;
    assign ram_wdata_o   = wdata_q;
    assign swap_done_o   = swap_done_q;

endmodule

// File: tb/tb_red_pitaya_asg_bank_ctrl.sv
`timescale 1ns/1ps
module tb_red_pitaya_asg_bank_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        gen_wrap = 1'b0;
    logic        gen_idle = 1'b0;
    logic        bank_sel;
    logic [1:0]  ram_we;
    logic [14:0] ram_waddr;
    logic [13:0] ram_wdata;
    logic        swap_done;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] CSR = 32'h80;

    red_pitaya_asg_bank_ctrl_if bus();

    red_pitaya_asg_bank_ctrl dut (
        .dac_clk_i   (clk),
        .dac_rst_i   (rst),
        .sys         (bus),
        .gen_wrap_i  (gen_wrap),
        .gen_idle_i  (gen_idle),
        .bank_sel_o  (bank_sel),
        .ram_we_o    (ram_we),
        .ram_waddr_o (ram_waddr),
        .ram_wdata_o (ram_wdata),
        .swap_done_o (swap_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus.sys_addr  = a;
        bus.sys_wdata = d;
        bus.sys_wen   = 1'b1;
        tick();
        bus.sys_wen   = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a);
        bus.sys_addr = a;
        bus.sys_ren  = 1'b1;
        tick();
        bus.sys_ren  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_tests++;
        if ({bus.sys_ack, bus.sys_err, bus.sys_rdata, ram_we, ram_waddr, ram_wdata, swap_done, bank_sel} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: ack=%b err=%b rdata=%h we=%b waddr=%h wdata=%h done=%b bank=%b, required all 0",
                     bus.sys_ack, bus.sys_err, bus.sys_rdata, ram_we, ram_waddr, ram_wdata, swap_done, bank_sel);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_shadow_write();
        bus_write(32'h40000, 32'd3);
        n_tests++;
        if ({bus.sys_ack, bus.sys_err, ram_we, ram_waddr, ram_wdata} !== {1'b1, 1'b0, 2'b10, 15'd0, 14'd3}) begin
            n_fail++;
            $display("FAIL shadow_write: ack=%b err=%b we=%b waddr=%h wdata=%h, required 1 0 10 0 3",
                     bus.sys_ack, bus.sys_err, ram_we, ram_waddr, ram_wdata);
        end
        tick();
        n_tests++;
        if ({bus.sys_ack, ram_we} !== 3'b000) begin
            n_fail++;
            $display("FAIL shadow_write_pulse: ack=%b we=%b, required 0 00", bus.sys_ack, ram_we);
        end
    endtask

    task automatic test_active_write();
        gen_idle = 1'b0;
        bus_write(32'h20008, 32'd5);
        n_tests++;
        if ({bus.sys_ack, bus.sys_err, ram_we} !== {1'b1, 1'b1, 2'b00}) begin
            n_fail++;
            $display("FAIL active_write_running: ack=%b err=%b we=%b, required 1 1 00", bus.sys_ack, bus.sys_err, ram_we);
        end
        gen_idle = 1'b1;
        bus_write(32'h20004, 32'd7);
        n_tests++;
        if ({bus.sys_ack, bus.sys_err, ram_we, ram_waddr, ram_wdata} !== {1'b1, 1'b0, 2'b01, 15'd1, 14'd7}) begin
            n_fail++;
            $display("FAIL active_write_idle: ack=%b err=%b we=%b waddr=%h wdata=%h, required 1 0 01 1 7",
                     bus.sys_ack, bus.sys_err, ram_we, ram_waddr, ram_wdata);
        end
        gen_idle = 1'b0;
        tick();
    endtask

    task automatic test_arm_wrap();
        bit early = 1'b0;
        bus_write(CSR, 32'd1);
        n_tests++;
        if ({bus.sys_ack, bus.sys_err} !== 2'b10) begin
            n_fail++;
            $display("FAIL arm_ack: ack=%b err=%b, required 1 0", bus.sys_ack, bus.sys_err);
        end
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bank_sel !== 1'b0 || swap_done !== 1'b0) early = 1'b1;
        end
        n_tests++;
        if (early) begin
            n_fail++;
            $display("FAIL arm_no_early_swap: bank=%b done=%b, required 0 0 before wrap", bank_sel, swap_done);
        end
        gen_wrap = 1'b1;
        tick();
        gen_wrap = 1'b0;
        n_tests++;
        if ({bank_sel, swap_done} !== 2'b11) begin
            n_fail++;
            $display("FAIL wrap_swap: bank=%b done=%b, required 1 1", bank_sel, swap_done);
        end
        tick();
        n_tests++;
        if ({bank_sel, swap_done} !== 2'b10) begin
            n_fail++;
            $display("FAIL swap_done_width: bank=%b done=%b, required 1 0", bank_sel, swap_done);
        end
        bus_read(CSR);
        n_tests++;
        if ({bus.sys_ack, bus.sys_err, bus.sys_rdata} !== {1'b1, 1'b0, 32'h0001_0002}) begin
            n_fail++;
            $display("FAIL csr_after_swap: ack=%b err=%b rdata=%h, required 1 0 00010002",
                     bus.sys_ack, bus.sys_err, bus.sys_rdata);
        end
    endtask

    task automatic test_pending_cancel();
        bus_write(CSR, 32'd1);
        tick();
        bus_write(32'h20000, 32'd9);
        n_tests++;
        if ({bus.sys_ack, bus.sys_err, ram_we} !== {1'b1, 1'b1, 2'b00}) begin
            n_fail++;
            $display("FAIL pending_shadow_frozen: ack=%b err=%b we=%b, required 1 1 00", bus.sys_ack, bus.sys_err, ram_we);
        end
        bus.sys_addr  = CSR;
        bus.sys_wdata = 32'd2;
        bus.sys_wen   = 1'b1;
        gen_wrap      = 1'b1;
        tick();
        bus.sys_wen   = 1'b0;
        gen_wrap      = 1'b0;
        n_tests++;
        if ({bus.sys_ack, bus.sys_err, bank_sel, swap_done} !== 4'b1010) begin
            n_fail++;
            $display("FAIL cancel_vs_wrap: ack=%b err=%b bank=%b done=%b, required 1 0 1 0",
                     bus.sys_ack, bus.sys_err, bank_sel, swap_done);
        end
        tick();
        gen_wrap = 1'b1;
        tick();
        gen_wrap = 1'b0;
        tick();
        n_tests++;
        if ({bank_sel, swap_done} !== 2'b10) begin
            n_fail++;
            $display("FAIL cancel_then_wrap: bank=%b done=%b, required 1 0", bank_sel, swap_done);
        end
        bus_read(CSR);
        n_tests++;
        if (bus.sys_rdata !== 32'h0001_0002) begin
            n_fail++;
            $display("FAIL csr_after_cancel: rdata=%h, required 00010002", bus.sys_rdata);
        end
    endtask

    task automatic test_force();
        bit moved = 1'b0;
        gen_idle = 1'b0;
        bus_write(CSR, 32'd4);
        n_tests++;
        if ({bus.sys_ack, bus.sys_err} !== 2'b11) begin
            n_fail++;
            $display("FAIL force_running: ack=%b err=%b, required 1 1", bus.sys_ack, bus.sys_err);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bank_sel !== 1'b1 || swap_done !== 1'b0) moved = 1'b1;
        end
        n_tests++;
        if (moved) begin
            n_fail++;
            $display("FAIL force_running_no_flip: bank=%b done=%b, required 1 0", bank_sel, swap_done);
        end
        gen_idle = 1'b1;
        bus_write(CSR, 32'd4);
        n_tests++;
        if ({bus.sys_ack, bus.sys_err, bank_sel} !== 3'b101) begin
            n_fail++;
            $display("FAIL force_idle_ack: ack=%b err=%b bank=%b, required 1 0 1", bus.sys_ack, bus.sys_err, bank_sel);
        end
        tick();
        n_tests++;
        if ({bank_sel, swap_done} !== 2'b01) begin
            n_fail++;
            $display("FAIL force_idle_flip: bank=%b done=%b, required 0 1", bank_sel, swap_done);
        end
        gen_idle = 1'b0;
        tick();
        bus_write(CSR, 32'd5);
        n_tests++;
        if ({bus.sys_ack, bus.sys_err} !== 2'b10) begin
            n_fail++;
            $display("FAIL arm_force_as_arm: ack=%b err=%b, required 1 0", bus.sys_ack, bus.sys_err);
        end
        tick();
        gen_wrap = 1'b1;
        tick();
        gen_wrap = 1'b0;
        n_tests++;
        if ({bank_sel, swap_done} !== 2'b11) begin
            n_fail++;
            $display("FAIL arm_force_wrap_swap: bank=%b done=%b, required 1 1", bank_sel, swap_done);
        end
        bus_read(CSR);
        n_tests++;
        if (bus.sys_rdata !== 32'h0003_0002) begin
            n_fail++;
            $display("FAIL csr_count3: rdata=%h, required 00030002", bus.sys_rdata);
        end
    endtask

    task automatic test_reset_pending();
        bus_write(CSR, 32'd1);
        tick();
        rst = 1'b1;
        tick();
        n_tests++;
        if ({bank_sel, swap_done, bus.sys_ack, ram_we} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_pending: bank=%b done=%b ack=%b we=%b, required all 0", bank_sel, swap_done, bus.sys_ack, ram_we);
        end
        rst = 1'b0;
        bus_read(CSR);
        n_tests++;
        if ({bus.sys_ack, bus.sys_rdata} !== {1'b1, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_status: ack=%b rdata=%h, required 1 00000000", bus.sys_ack, bus.sys_rdata);
        end
        gen_wrap = 1'b1;
        tick();
        gen_wrap = 1'b0;
        n_tests++;
        if ({bank_sel, swap_done} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_lost_request: bank=%b done=%b, required 0 0", bank_sel, swap_done);
        end
    endtask

    task automatic test_swap_cycle_write();
        bus_write(CSR, 32'd1);
        tick();
        gen_wrap = 1'b1;
        tick();
        gen_wrap = 1'b0;
        bus_write(32'h40010, 32'd11);
        n_tests++;
        if ({bus.sys_ack, bus.sys_err, ram_we, ram_waddr, ram_wdata} !== {1'b1, 1'b0, 2'b10, 15'd4, 14'd11}) begin
            n_fail++;
            $display("FAIL swap_cycle_write: ack=%b err=%b we=%b waddr=%h wdata=%h, required 1 0 10 4 b",
                     bus.sys_ack, bus.sys_err, ram_we, ram_waddr, ram_wdata);
        end
    endtask

    // Randomized traffic checked against a transaction-level model of the bank rules.
    task automatic test_random();
        bit          m_bank = 1'b0, m_pend = 1'b0, m_swap = 1'b0;
        bit          q_arm = 1'b0, q_cancel = 1'b0, q_force = 1'b0;
        int unsigned m_cnt = 0;
        logic [14:0] m_waddr = '0;
        logic [13:0] m_wdata = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            bit e_ack, e_err, e_done, n_arm, n_cancel, n_force, cancel_now, go;
            logic [31:0] e_rdata, a, d;
            logic [1:0]  e_we;
            bit          in_b0, in_b1, in_csr, wen, ren, played, ok;
            int          kind;
            bit          rs;
            rs = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 29) == 0) gen_idle = ~gen_idle;
            gen_wrap = ($urandom_range(0, 14) == 0);
            kind = $urandom_range(0, 5);
            case (kind)
                0, 5:    a = CSR;
                1:       a = 32'h20000 + ($urandom_range(0, 32767) << 2);
                2:       a = 32'h40000 + ($urandom_range(0, 32767) << 2);
                3:       a = ($urandom_range(0, 1) == 0) ? 32'h1FFFC : 32'h60000;
                default: a = ($urandom_range(0, 1) == 0) ? 32'h3FFFC : 32'h5FFFC;
            endcase
            d = $urandom();
            wen = ($urandom_range(0, 2) == 0);
            ren = !wen && ($urandom_range(0, 3) == 0);
            rst = rs;
            bus.sys_addr = a; bus.sys_wdata = d; bus.sys_wen = wen; bus.sys_ren = ren;

            in_b0  = (a >= 32'h20000) && (a < 32'h40000);
            in_b1  = (a >= 32'h40000) && (a < 32'h60000);
            in_csr = (a == CSR);
            e_ack = 0; e_err = 0; e_rdata = 0; e_we = 0; e_done = 0;
            n_arm = 0; n_cancel = 0; n_force = 0; cancel_now = 0;
            if (rs) begin
                m_bank = 0; m_pend = 0; m_swap = 0; m_cnt = 0;
                q_arm = 0; q_cancel = 0; q_force = 0; m_waddr = 0; m_wdata = 0;
            end else begin
                if (wen && in_csr) begin
                    e_ack = 1;
                    e_err = d[2] && !gen_idle && !d[0];
                    n_force = d[2] && gen_idle;
                    n_arm = d[0] && !n_force;
                    n_cancel = d[1];
                    cancel_now = d[1];
                end else if (wen && (in_b0 || in_b1)) begin
                    e_ack = 1;
                    played = m_swap ? !m_bank : m_bank;
                    ok = (in_b1 == played) ? gen_idle : !m_pend;
                    if (ok) begin
                        e_we = in_b1 ? 2'b10 : 2'b01;
                        m_waddr = a[16:2];
                        m_wdata = d[13:0];
                    end else begin
                        e_err = 1;
                    end
                end else if (ren && in_csr) begin
                    e_ack = 1;
                    e_rdata = (m_cnt % 65536) * 65536 + m_pend * 4 + m_bank * 2 + gen_idle;
                end else if (ren && (in_b0 || in_b1)) begin
                    e_ack = 1;
                    e_err = 1;
                end
                go = 0;
                if (m_swap) m_pend = 0;
                else if (!m_pend) begin
                    if (q_force) go = 1;
                    else if (q_arm) m_pend = 1;
                end else begin
                    if (q_cancel) m_pend = 0;
                    else if (cancel_now) m_pend = 1;
                    else if (gen_wrap || gen_idle) begin m_pend = 0; go = 1; end
                end
                m_swap = go;
                if (go) begin m_bank = !m_bank; m_cnt++; e_done = 1; end
                q_arm = n_arm; q_cancel = n_cancel; q_force = n_force;
            end
            tick();
            n_tests++;
            if (bus.sys_ack !== e_ack || bus.sys_err !== e_err || bus.sys_rdata !== e_rdata || ram_we !== e_we ||
                bank_sel !== m_bank || swap_done !== e_done ||
                (e_we != 2'b00 && (ram_waddr !== m_waddr || ram_wdata !== m_wdata))) begin
                n_fail++;
                $display("FAIL random_cycle%0d: ack=%b err=%b rdata=%h we=%b bank=%b done=%b waddr=%h wdata=%h, required %b %b %h %b %b %b %h %h",
                         i, bus.sys_ack, bus.sys_err, bus.sys_rdata, ram_we, bank_sel, swap_done, ram_waddr, ram_wdata,
                         e_ack, e_err, e_rdata, e_we, m_bank, e_done, m_waddr, m_wdata);
            end
        end
        rst = 1'b0;
        bus.sys_wen = 1'b0;
        bus.sys_ren = 1'b0;
        gen_wrap = 1'b0;
    endtask

    initial begin
        bus.sys_addr  = 32'd0;
        bus.sys_wdata = 32'd0;
        bus.sys_wen   = 1'b0;
        bus.sys_ren   = 1'b0;
        test_reset();
        test_shadow_write();
        test_active_write();
        test_arm_wrap();
        test_pending_cancel();
        test_force();
        test_reset_pending();
        test_swap_cycle_write();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
